// File: rtl/inv_sched.sv
// Two-requester round-robin scheduler feeding a shared XOR-mask inverter with a one-word output stage.
// Optional per-requester saturating grant counters are enabled by defining INV_SCHED_STATS_EN.
module inv_sched #(
   parameter int          N        = 8,
   parameter logic [N-1:0] MASK_RST = N'(8'h55)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic         req1_valid,
   input  logic [N-1:0] req0_data,
   input  logic [N-1:0] req1_data,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic         mask_load,
   input  logic [N-1:0] mask_in,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic         out_id,
   input  logic         out_ready,
   output logic         busy,
   output logic [7:0]   cnt0,
   output logic [7:0]   cnt1
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] out_data_q, out_data_d;
   logic [N-1:0] mask_q, mask_d;
   logic         out_id_q, out_id_d;
   logic         last_q, last_d;
   logic         slot_free_s, grant0_s, grant1_s;

   // Arbitration and next-state: last_q=1 means requester 1 was granted last, so requester 0 wins a tie.
   always_comb begin
      slot_free_s = (state_q == EMPTY) | out_ready;
      grant0_s    = 1'b0;
      grant1_s    = 1'b0;
      if (!reset && slot_free_s) begin
         case ({req1_valid, req0_valid})
            2'b01:   grant0_s = 1'b1;
            2'b10:   grant1_s = 1'b1;
            2'b11: begin
               if (last_q) begin
                  grant0_s = 1'b1;
               end else begin
                  grant1_s = 1'b1;
               end
            end
            default: grant0_s = 1'b0;
         endcase
      end else begin
         grant0_s = 1'b0;
      end

      state_d    = state_q;
      out_data_d = out_data_q;
      out_id_d   = out_id_q;
      last_d     = last_q;
      if (grant0_s || grant1_s) begin
         state_d    = FULL;
         out_data_d = (grant1_s ? req1_data : req0_data) ^ mask_q;
         out_id_d   = grant1_s;
         last_d     = grant1_s;
      end else if (out_ready) begin
         state_d = EMPTY;
      end else begin
         state_d = state_q;
      end

      mask_d = mask_load ? mask_in : mask_q;
   end

   // Output stage FSM, mask and round-robin pointer; reset overrides every other update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_id_q   <= 1'b0;
         mask_q     <= MASK_RST;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
         mask_q     <= mask_d;
         last_q     <= last_d;
      end
   end

   assign req0_ready = grant0_s;
   assign req1_ready = grant1_s;
   assign out_valid  = (state_q == FULL);
   assign busy       = (state_q == FULL);
   assign out_data   = out_data_q;
   assign out_id     = out_id_q;

`ifdef INV_SCHED_STATS_EN
   logic [7:0] cnt0_q, cnt0_d;
   logic [7:0] cnt1_q, cnt1_d;

   // Saturating grant counters.
   always_comb begin
      if (grant0_s && (cnt0_q != 8'hFF)) begin
         cnt0_d = cnt0_q + 8'd1;
      end else begin
         cnt0_d = cnt0_q;
      end
      if (grant1_s && (cnt1_q != 8'hFF)) begin
         cnt1_d = cnt1_q + 8'd1;
      end else begin
         cnt1_d = cnt1_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= 8'd0;
         cnt1_q <= 8'd0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`else
   assign cnt0 = 8'd0;
   assign cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_inv_sched.sv
// Self-checking bench for inv_sched: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model of the scheduler.
module tb_inv_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       mask_load;
   logic [7:0] mask_in;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_id;
   logic       out_ready;
   logic       busy;
   logic [7:0] cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: held word, its source, who wins the next tie, mask, grant totals.
   logic       m_full;
   logic [7:0] m_data;
   logic       m_id;
   int         m_pref;
   logic [7:0] m_mask;
   int         m_c0, m_c1;

   inv_sched #(.N(8)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_data(req0_data), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .mask_load(mask_load), .mask_in(mask_in),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
      .out_ready(out_ready), .busy(busy),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_cnt(input int c);
`ifdef INV_SCHED_STATS_EN
      return (c > 255) ? 255 : c;
`else
      return 0;
`endif
   endfunction

   task automatic cycle(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                        input logic ml, input logic [7:0] mi, input logic ordy, input logic rst);
      int g;
      @(negedge clk);
      req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
      mask_load = ml; mask_in = mi; out_ready = ordy; reset = rst;
      #1;
      g = -1;
      if (!rst && (!m_full || ordy)) begin
         if (v0 && v1)  g = m_pref;
         else if (v0)   g = 0;
         else if (v1)   g = 1;
      end
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, (g == 0)});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, (g == 1)});
      @(posedge clk);
      if (rst) begin
         m_full = 1'b0; m_data = 8'h00; m_id = 1'b0; m_pref = 0;
         m_mask = 8'h55; m_c0 = 0; m_c1 = 0;
      end else begin
         if (g >= 0) begin
            m_data = ((g == 1) ? d1 : d0) ^ m_mask;
            m_id   = g[0];
            m_full = 1'b1;
            m_pref = 1 - g;
            if (g == 0) m_c0++; else m_c1++;
         end else if (ordy) begin
            m_full = 1'b0;
         end
         if (ml) m_mask = mi;
      end
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("busy", {31'd0, busy}, {31'd0, m_full});
      if (m_full || rst) begin
         chk("out_data", {24'd0, out_data}, {24'd0, m_data});
         chk("out_id", {31'd0, out_id}, {31'd0, m_id});
      end
      chk("cnt0", {24'd0, cnt0}, exp_cnt(m_c0));
      chk("cnt1", {24'd0, cnt1}, exp_cnt(m_c1));
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, ordy, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1, 8'hAA, 1'b1, 1'b1);
   endtask

   initial begin
      logic [7:0] held;
      m_full = 1'b0; m_data = 8'h00; m_id = 1'b0; m_pref = 0; m_mask = 8'h55; m_c0 = 0; m_c1 = 0;
      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
      mask_load = 1'b0; mask_in = 8'h00; out_ready = 1'b0;

      do_reset();
      do_reset();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);

      // First word after reset picks up the reset mask.
      cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("first_data", {24'd0, out_data}, 32'h55);
      chk("first_id", {31'd0, out_id}, 32'd0);
      idle(1'b1);

      // Contending requesters alternate starting with req0.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 8'(i), 1'b1, 8'(8'h80 + i), 1'b0, 8'h00, 1'b1, 1'b0);
         chk("alt_id", {31'd0, out_id}, i % 2);
         chk("alt_valid", {31'd0, out_valid}, 32'd1);
      end
      idle(1'b1);

      // Backpressure holds the word and blocks both requesters.
      cycle(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      held = out_data;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
         chk("stall_data", {24'd0, out_data}, {24'd0, held});
         chk("stall_busy", {31'd0, busy}, 32'd1);
      end
      idle(1'b1);
      chk("drained", {31'd0, out_valid}, 32'd0);

      // Mask written alongside a grant applies from the following word.
      do_reset();
      cycle(1'b1, 8'h0F, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      chk("oldmask", {24'd0, out_data}, 32'h5A);
      cycle(1'b1, 8'h0F, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("newmask", {24'd0, out_data}, 32'hF0);

      // Reset while holding a word discards it and restores the mask.
      cycle(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);
      do_reset();
      chk("rstfull_valid", {31'd0, out_valid}, 32'd0);
      chk("rstfull_data", {24'd0, out_data}, 32'd0);
      chk("rstfull_cnt", {16'd0, cnt1, cnt0}, 32'd0);
      cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("rstfull_mask", {24'd0, out_data}, 32'h55);

      // Counter saturation.
      do_reset();
      for (int i = 0; i < 300; i++)
         cycle(1'b1, 8'($urandom), 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef INV_SCHED_STATS_EN
      chk("sat_cnt0", {24'd0, cnt0}, 32'd255);
`else
      chk("sat_cnt0", {24'd0, cnt0}, 32'd0);
`endif
      chk("sat_cnt1", {24'd0, cnt1}, 32'd0);

      // Random traffic.
      for (int i = 0; i < 1500; i++)
         cycle(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
               ($urandom_range(9, 0) == 0), 8'($urandom),
               ($urandom_range(3, 0) != 0), ($urandom_range(39, 0) == 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
